// File: rtl/adsr_poly.sv
// Polyphonic linear ADSR envelope generator.
// One shared adder is time-multiplexed across VOICES envelopes, one voice per clock.
// A sample_tick starts a step. Voice v is processed in slot T+1+v, and its result is
// registered out in cycle T+2+v.
module adsr_poly #(
    parameter int unsigned VOICES              = 8,
    parameter int unsigned TOTAL_BITS          = 48,
    parameter int unsigned FRACTIONAL_BITS     = 32,
    parameter int unsigned AMPLITUDE_BITS      = 16,
    parameter int unsigned RETRIGGER_FROM_ZERO = 0,
    localparam int unsigned VW = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic signed [TOTAL_BITS-1:0] attack_time,
    input  logic signed [TOTAL_BITS-1:0] decay_time,
    input  logic [AMPLITUDE_BITS-1:0]    sustain,
    input  logic signed [TOTAL_BITS-1:0] release_time,
    input  logic [VOICES-1:0]            gate,
    output logic                         out_valid,
    output logic [VW-1:0]                out_voice,
    output logic [AMPLITUDE_BITS-1:0]    out,
    output logic [VOICES-1:0]            active,
    output logic                         busy
);

    localparam int unsigned LW = TOTAL_BITS + 1;
    localparam int unsigned SUS_SHIFT = FRACTIONAL_BITS - AMPLITUDE_BITS;
    localparam logic [TOTAL_BITS-1:0] LEVEL_ONE = TOTAL_BITS'(1) << FRACTIONAL_BITS;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Per-voice envelope state.
    logic [2:0]            state_q [VOICES];
    logic [TOTAL_BITS-1:0] level_q [VOICES];
    logic [VOICES-1:0]     gprev_q;

    // Parameters and gates latched at step start.
    logic signed [TOTAL_BITS-1:0] att_q;
    logic signed [TOTAL_BITS-1:0] dec_q;
    logic signed [TOTAL_BITS-1:0] rel_q;
    logic [AMPLITUDE_BITS-1:0]    sus_q;
    logic [VOICES-1:0]            gate_q;

    // Slot sequencing.
    logic          proc_q;
    logic [VW-1:0] cnt_q;
    logic          busy_q;
    logic          accept;

    // Registered outputs.
    logic                      out_valid_q;
    logic [VW-1:0]             out_voice_q;
    logic [AMPLITUDE_BITS-1:0] out_q;
    logic [VOICES-1:0]         active_q;

    // Datapath for the voice in the current slot.
    logic [2:0]                cur_st;
    logic [TOTAL_BITS-1:0]     cur_lv;
    logic                      rise;
    logic                      fall;
    logic [2:0]                eff_st;
    logic [TOTAL_BITS-1:0]     eff_lv;
    logic [TOTAL_BITS-1:0]     sus_lvl;
    logic signed [LW-1:0]      lv_x;
    logic signed [LW-1:0]      one_x;
    logic signed [LW-1:0]      sus_x;
    logic signed [LW-1:0]      sum_a;
    logic signed [LW-1:0]      dif_d;
    logic signed [LW-1:0]      dif_r;
    logic                      att_np;
    logic                      dec_np;
    logic                      rel_np;
    logic [2:0]                st_d;
    logic [TOTAL_BITS-1:0]     lv_d;
    logic [AMPLITUDE_BITS-1:0] out_d;

    assign accept    = sample_tick & ~busy_q;
    assign out_valid = out_valid_q;
    assign out_voice = out_voice_q;
    assign out       = out_q;
    assign active    = active_q;
    assign busy      = busy_q;

    // Next state and level for the voice in the current slot: gate edge first, then one step.
    always_comb begin
        cur_st  = state_q[cnt_q];
        cur_lv  = level_q[cnt_q];
        rise    = gate_q[cnt_q] & ~gprev_q[cnt_q];
        fall    = ~gate_q[cnt_q] & gprev_q[cnt_q];
        eff_st  = cur_st;
        eff_lv  = cur_lv;
        sus_lvl = TOTAL_BITS'(sus_q) << SUS_SHIFT;
        att_np  = att_q[TOTAL_BITS-1] | (att_q == '0);
        dec_np  = dec_q[TOTAL_BITS-1] | (dec_q == '0);
        rel_np  = rel_q[TOTAL_BITS-1] | (rel_q == '0);

        // Gate-edge transitions take effect before this slot's step.
        case (cur_st)
            ST_IDLE: begin
                eff_lv = '0;
                if (rise) begin
                    eff_st = ST_ATTACK;
                end
            end
            ST_ATTACK, ST_DECAY, ST_SUSTAIN: begin
                if (fall) begin
                    eff_st = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rise) begin
                    eff_st = ST_ATTACK;
                    if (RETRIGGER_FROM_ZERO != 0) begin
                        eff_lv = '0;
                    end
                end
            end
            default: begin
                eff_st = ST_IDLE;
                eff_lv = '0;
            end
        endcase

        // Widened arithmetic. Levels never exceed 1.0, so the sign bit is always zero.
        lv_x  = $signed({1'b0, eff_lv});
        one_x = $signed({1'b0, LEVEL_ONE});
        sus_x = $signed({1'b0, sus_lvl});
        sum_a = lv_x + $signed({att_q[TOTAL_BITS-1], att_q});
        dif_d = lv_x - $signed({dec_q[TOTAL_BITS-1], dec_q});
        dif_r = lv_x - $signed({rel_q[TOTAL_BITS-1], rel_q});

        st_d = eff_st;
        lv_d = eff_lv;
        case (eff_st)
            ST_IDLE: begin
                lv_d = '0;
            end
            ST_ATTACK: begin
                if (att_np || (sum_a >= one_x)) begin
                    lv_d = LEVEL_ONE;
                    st_d = ST_DECAY;
                end else begin
                    lv_d = sum_a[TOTAL_BITS-1:0];
                end
            end
            ST_DECAY: begin
                if (dec_np || (dif_d <= sus_x)) begin
                    lv_d = sus_lvl;
                    st_d = ST_SUSTAIN;
                end else begin
                    lv_d = dif_d[TOTAL_BITS-1:0];
                end
            end
            ST_SUSTAIN: begin
                lv_d = sus_lvl;
            end
            ST_RELEASE: begin
                if (rel_np || (dif_r <= $signed(LW'(0)))) begin
                    lv_d = '0;
                    st_d = ST_IDLE;
                end else begin
                    lv_d = dif_r[TOTAL_BITS-1:0];
                end
            end
            default: begin
                lv_d = '0;
                st_d = ST_IDLE;
            end
        endcase

        // A full-scale level saturates the output. Otherwise the fraction is truncated.
        if (lv_d >= LEVEL_ONE) begin
            out_d = '1;
        end else begin
            out_d = lv_d[FRACTIONAL_BITS-1 -: AMPLITUDE_BITS];
        end
    end

    // Step sequencing, parameter latching, and per-voice state write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < int'(VOICES); v++) begin
                state_q[v] <= ST_IDLE;
                level_q[v] <= '0;
            end
            gprev_q     <= '0;
            att_q       <= '0;
            dec_q       <= '0;
            rel_q       <= '0;
            sus_q       <= '0;
            gate_q      <= '0;
            proc_q      <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_voice_q <= '0;
            out_q       <= '0;
            active_q    <= '0;
        end else begin
            busy_q      <= accept | proc_q;
            out_valid_q <= proc_q;
            if (accept) begin
                att_q  <= attack_time;
                dec_q  <= decay_time;
                rel_q  <= release_time;
                sus_q  <= sustain;
                gate_q <= gate;
                cnt_q  <= '0;
                proc_q <= 1'b1;
            end else if (proc_q) begin
                state_q[cnt_q]  <= st_d;
                level_q[cnt_q]  <= lv_d;
                gprev_q[cnt_q]  <= gate_q[cnt_q];
                active_q[cnt_q] <= (st_d != ST_IDLE);
                out_voice_q     <= cnt_q;
                out_q           <= out_d;
                if (cnt_q == VW'(VOICES - 1)) begin
                    proc_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + VW'(1);
                end
            end
        end
    end

endmodule
